// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: shifts a WIDTH-bit payload out MSB first, then idles GAP cycles.
// Build option: define SERIAL_PATTERN_TX_PARITY_EN to append an odd-parity bit to each frame.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for load; ready=1
// ST_SHIFT   | driving payload bits MSB first, out_valid=1
// ST_PARITY  | driving odd-parity bit with done=1 (parity build only)
// ST_GAP     | inter-frame idle for GAP cycles, ready=0

module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_GAP    = 2'd2,
        ST_PARITY = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             ready_q, ready_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            ready_q     <= 1'b1;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            ready_q     <= ready_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shift_d = din;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    par_d   = ~^din;
`endif
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
`endif
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                end
            end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            ST_PARITY: begin
                if (GAP > 0) begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            ST_GAP: begin
                // Down-counter loaded with GAP; leaving at 1 gives exactly GAP idle cycles.
                if (gap_q <= GW'(1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output flops are loaded from the next-state view so each output is a clean register.
    always_comb begin
        ready_d     = (state_d == ST_IDLE);
        out_valid_d = 1'b0;
        out_d       = 1'b0;
        done_d      = 1'b0;
        if (state_d == ST_SHIFT) begin
            out_valid_d = 1'b1;
            out_d       = shift_d[WIDTH-1];
`ifndef SERIAL_PATTERN_TX_PARITY_EN
            done_d      = (cnt_d == LAST_BIT);
`endif
        end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        if (state_d == ST_PARITY) begin
            out_valid_d = 1'b1;
            out_d       = par_d;
            done_d      = 1'b1;
        end
`endif
    end

    assign ready     = ready_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: three parameterisations checked every cycle against a
// frame-queue reference model, with directed scenarios followed by random traffic.
module tb_serial_pattern_tx;

    localparam int WA = 8, GA = 2;
    localparam int WB = 8, GB = 0;
    localparam int WC = 5, GC = 3;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] din_ab = 8'h00;
    logic [4:0] din_c = 5'h00;

    logic ready_a, out_a, valid_a, done_a;
    logic ready_b, out_b, valid_b, done_b;
    logic ready_c, out_c, valid_c, done_c;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Each entry is one future output cycle: {out, out_valid, done}. Empty queue means idle/ready.
    typedef logic [2:0] ent_t;
    ent_t mq[3][$];

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(WA), .GAP(GA)) dut_a (
        .clk(clk), .rst(rst), .load(load), .din(din_ab),
        .ready(ready_a), .out(out_a), .out_valid(valid_a), .done(done_a));

    serial_pattern_tx #(.WIDTH(WB), .GAP(GB)) dut_b (
        .clk(clk), .rst(rst), .load(load), .din(din_ab),
        .ready(ready_b), .out(out_b), .out_valid(valid_b), .done(done_b));

    serial_pattern_tx #(.WIDTH(WC), .GAP(GC)) dut_c (
        .clk(clk), .rst(rst), .load(load), .din(din_c),
        .ready(ready_c), .out(out_c), .out_valid(valid_c), .done(done_c));

    task automatic model_edge(input int id, input logic [31:0] d, input int w, input int gap);
        int ones;
        ones = 0;
        if (!rst) begin
            mq[id].delete();
        end else if (mq[id].size() != 0) begin
            void'(mq[id].pop_front());
        end else if (load) begin
            for (int i = w - 1; i >= 0; i--) begin
                ones += int'(d[i]);
                mq[id].push_back({d[i], 1'b1, ((i == 0) && !PAR)});
            end
            if (PAR) mq[id].push_back({((ones % 2) == 0), 1'b1, 1'b1});
            for (int g = 0; g < gap; g++) mq[id].push_back(3'b000);
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_inst(input int id, input string pfx,
                            input logic r, input logic o, input logic v, input logic dn);
        ent_t e;
        logic er;
        if (mq[id].size() != 0) begin
            e  = mq[id][0];
            er = 1'b0;
        end else begin
            e  = 3'b000;
            er = 1'b1;
        end
        chk({pfx, "_ready"}, r, er);
        chk({pfx, "_out"}, o, e[2]);
        chk({pfx, "_out_valid"}, v, e[1]);
        chk({pfx, "_done"}, dn, e[0]);
    endtask

    task automatic cyc(input logic ld, input logic rs, input logic [7:0] dab);
        load   = ld;
        rst    = rs;
        din_ab = dab;
        din_c  = 5'($urandom);
        @(posedge clk);
        model_edge(0, {24'h0, din_ab}, WA, GA);
        model_edge(1, {24'h0, din_ab}, WB, GB);
        model_edge(2, {27'h0, din_c}, WC, GC);
        #1;
        chk_inst(0, "a", ready_a, out_a, valid_a, done_a);
        chk_inst(1, "b", ready_b, out_b, valid_b, done_b);
        chk_inst(2, "c", ready_c, out_c, valid_c, done_c);
    endtask

    initial begin
        logic [7:0] bits;
        int         dones;

        // Reset, including a load asserted during reset which must be ignored.
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'hC3);
        cyc(1'b0, 1'b0, 8'h00);
        chk("reset_ready_a", ready_a, 1'b1);
        chk("reset_out_valid_a", valid_a, 1'b0);

        // 8'hA5 frame: collect serial bits and done pulses directly.
        cyc(1'b1, 1'b1, 8'hA5);
        bits  = 8'h00;
        dones = 0;
        for (int k = 1; k <= 8; k++) begin
            bits = {bits[6:0], out_a};
            if (done_a) dones++;
            if (k < 8) cyc(1'b0, 1'b1, 8'($urandom));
        end
        n_total++;
        assert (bits === 8'hA5) n_pass++;
        else begin
            n_fail++;
            $error("FAIL a5_serial_bits observed=%h expected=%h", bits, 8'hA5);
        end
        n_total++;
        assert (dones == 1 && done_a === 1'b1) n_pass++;
        else begin
            n_fail++;
            $error("FAIL a5_done_count observed=%0d expected=1", dones);
        end
        for (int k = 0; k < 14; k++) cyc(1'b0, 1'b1, 8'h00);

        // load held high with 8'hFF during a frame: no effect until ready.
        cyc(1'b1, 1'b1, 8'hA5);
        for (int k = 0; k < 14; k++) cyc(1'b1, 1'b1, 8'hFF);
        for (int k = 0; k < 14; k++) cyc(1'b0, 1'b1, 8'h00);

        // Reset at the fourth edge of a frame, then a fresh frame two edges later.
        cyc(1'b1, 1'b1, 8'hA5);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        chk("midreset_ready_a", ready_a, 1'b1);
        chk("midreset_out_valid_a", valid_a, 1'b0);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 8'h3C);
        for (int k = 0; k < 14; k++) cyc(1'b0, 1'b1, 8'h00);

        // Back-to-back frames 8'h81 then 8'h7E; parity of 8'h01 exercised too.
        cyc(1'b1, 1'b1, 8'h81);
        for (int k = 0; k < 12; k++) cyc(1'b1, 1'b1, 8'h7E);
        for (int k = 0; k < 14; k++) cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 8'h01);
        for (int k = 0; k < 14; k++) cyc(1'b0, 1'b1, 8'h00);

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++)
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 49) != 0), 8'($urandom));
        for (int k = 0; k < 14; k++) cyc(1'b0, 1'b1, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the frame payload width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter GAP, default 2, giving the number of idle cycles inserted after each frame (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset, sampled on rising clk.
REQ-005 The block SHALL have port load, input, 1 bit: request to transmit din.
REQ-006 The block SHALL have port din, input, WIDTH bits: parallel payload, captured on load acceptance.
REQ-007 The block SHALL have port ready, output, 1 bit: high when a load will be accepted.
REQ-008 The block SHALL have port out, output, 1 bit: serial data line.
REQ-009 The block SHALL have port out_valid, output, 1 bit: high while out carries a frame bit.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the last bit of a frame.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, SHIFT and GAP, plus PARITY when enabled (see Configuration).
REQ-012 In IDLE: ready=1, out=0, out_valid=0, done=0.
REQ-013 Load acceptance: load=1 and ready=1 at a rising edge; din goes to the shift register, bit counter clears, state becomes SHIFT.
REQ-014 load while ready=0 SHALL be ignored, with no queuing and no effect on the frame in progress.
REQ-015 In SHIFT, bits SHALL go out MSB first: cycle k after acceptance (k=1..WIDTH) drives din[WIDTH-k] on out, with out_valid=1.
REQ-016 Latency SHALL be one cycle: the first bit appears in the cycle after the accepting edge.
REQ-017 done SHALL be 1 only in the cycle driving the final frame bit (last data bit, or the parity bit when enabled).
REQ-018 After the final bit, the FSM SHALL enter GAP for exactly GAP cycles, with out=0, out_valid=0 and ready=0.
REQ-019 If GAP=0, the FSM SHALL go straight to IDLE, so ready=1 in the cycle after the final bit.
REQ-020 The GAP counter SHALL be sized to hold GAP and SHALL NOT wrap or count past GAP.
REQ-021 The SHIFT bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL terminate at WIDTH-1 without wrapping.
REQ-022 din changes after acceptance SHALL NOT affect the frame in progress.
REQ-023 Outputs SHALL be registered; none SHALL depend combinationally on load or din.

Reset
REQ-024 When rst=0 at a rising edge, the block SHALL enter IDLE with ready=1, out=0, out_valid=0, done=0, and counters and shift register cleared.
REQ-025 Reset mid-frame (any state) SHALL abort the frame; no remaining bits are emitted.
REQ-026 Reset SHALL take priority over a simultaneous load.

Configuration
REQ-027 Macro SERIAL_PATTERN_TX_PARITY_EN SHALL control parity.
- Defined: after the last data bit, one PARITY cycle drives the odd-parity bit (set so total ones in data plus parity is odd), with out_valid=1 and done=1. The frame is WIDTH+1 bits.
- Undefined: no PARITY state or logic; the frame is WIDTH bits and done marks data bit WIDTH.

Verification
REQ-028 WIDTH=8, GAP=2, parity off: load din=8'hA5 at edge 0 -> out=1,0,1,0,0,1,0,1 in cycles 1-8, out_valid=1 in cycles 1-8, done in cycle 8, ready=0 in cycles 1-10, ready=1 in cycle 11.
REQ-029 Parity on, din=8'hA5 -> cycle 9 out=1 with done=1, ready=1 in cycle 12; din=8'h01 -> cycle 9 out=0.
REQ-030 load=1 held with din=8'hFF in cycles 1-10 during the 8'hA5 frame -> frame bits unchanged; the next frame is accepted only at the first edge with ready=1.
REQ-031 rst=0 at edge 4 of a frame -> cycle 5 shows out=0, out_valid=0, ready=1, done never pulses; a load at edge 6 starts a clean frame.
REQ-032 GAP=0, back-to-back loads of 8'h81 then 8'h7E -> the second frame's first bit appears 2 cycles after the first frame's done cycle, with no spurious done.
